// File: rtl/io_decoder.sv
// Address-window IO decoder: one access at a time, per-region wait states and read-only masking.
// Optional sticky unmapped-access flag built only when IO_DECODER_BUSERR_EN is defined.
module io_decoder #(
  parameter int                                 NUM_REGIONS = 4,
  parameter int                                 REGION_BITS = 3,
  parameter logic [NUM_REGIONS*REGION_BITS-1:0] REGION_BASE = {3'b111, 3'b000, 3'b110, 3'b101},
  parameter logic [NUM_REGIONS*2-1:0]           REGION_WAIT = '0,
  parameter logic [NUM_REGIONS-1:0]             REGION_RO   = 4'b0001,
  parameter logic [7:0]                         OPEN_BUS    = 8'hA5
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic [15:0]              A,
  input  logic [7:0]               DI,
  input  logic                     R_W_n,
  input  logic                     VALID,
  input  logic [NUM_REGIONS*8-1:0] RD_DATA,
  output logic [NUM_REGIONS-1:0]   SEL,
  output logic [NUM_REGIONS-1:0]   WE,
  output logic [7:0]               WD,
  output logic [7:0]               DO,
  output logic                     RDY,
  output logic                     BUSERR,
  output logic [15:0]              ERR_ADDR,
  input  logic                     ERR_CLR
);

  // state | meaning
  // IDLE  | waiting for VALID, no region selected
  // WAIT  | access latched, counting down region wait states
  // DONE  | access complete, RDY high for this single cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0]   sel_q, sel_d;
  logic [NUM_REGIONS-1:0]   we_q, we_d;
  logic                     rw_q, rw_d;
  logic [7:0]               wd_q, wd_d;
  logic [7:0]               do_q, do_d;

  logic                     hit;
  logic [NUM_REGIONS-1:0]   hit_sel;
  logic [1:0]               hit_wait;
  logic                     hit_ro;
  logic [7:0]               rd_sel;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_sel  = '0;
    hit_wait = 2'd0;
    hit_ro   = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (A[15 -: REGION_BITS] == REGION_BASE[i*REGION_BITS +: REGION_BITS]) begin
        hit        = 1'b1;
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit_wait   = REGION_WAIT[i*2 +: 2];
        hit_ro     = REGION_RO[i];
      end
    end
  end

  // The latched one-hot select doubles as the latched region index.
  always_comb begin
    rd_sel = 8'h00;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_q[i]) rd_sel = rd_sel | RD_DATA[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = '0;
    rw_d    = rw_q;
    wd_d    = wd_q;
    do_d    = do_q;
    case (state_q)
      IDLE: begin
        if (VALID) begin
          state_d = WAIT;
          cnt_d   = hit ? hit_wait : 2'd0;
          sel_d   = hit_sel;
          rw_d    = R_W_n;
          wd_d    = DI;
          if (!R_W_n && hit && !hit_ro) we_d = hit_sel;
        end
      end
      WAIT: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = DONE;
          if (rw_q) do_d = (|sel_q) ? rd_sel : OPEN_BUS;
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      sel_q   <= '0;
      we_q    <= '0;
      rw_q    <= 1'b1;
      wd_q    <= 8'h00;
      do_q    <= OPEN_BUS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rw_q    <= rw_d;
      wd_q    <= wd_d;
      do_q    <= do_d;
    end
  end

  assign SEL = sel_q;
  assign WE  = we_q;
  assign WD  = wd_q;
  assign DO  = do_q;
  assign RDY = (state_q == DONE);

`ifdef IO_DECODER_BUSERR_EN
  logic        buserr_q, buserr_d;
  logic [15:0] err_addr_q, err_addr_d;

  // A new fault outranks a clear on the same edge; only the first fault address is kept.
  always_comb begin
    buserr_d   = buserr_q;
    err_addr_d = err_addr_q;
    if (ERR_CLR) buserr_d = 1'b0;
    if ((state_q == IDLE) && VALID && !hit) begin
      buserr_d = 1'b1;
      if (!buserr_q) err_addr_d = A;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      buserr_q   <= 1'b0;
      err_addr_q <= 16'h0000;
    end else begin
      buserr_q   <= buserr_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign BUSERR   = buserr_q;
  assign ERR_ADDR = err_addr_q;
`else
  logic unused_ok;
  assign unused_ok = ^{ERR_CLR, A};

  assign BUSERR   = 1'b0;
  assign ERR_ADDR = 16'h0000;
`endif

endmodule

// File: tb/tb_io_decoder.sv
// Directed bench for io_decoder with a queue of expected access results.
// Region map here: r0=111x (RO, W0), r1=000x (W2), r2=110x (W3), r3=101x (W1).
module tb_io_decoder;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic [15:0] A;
  logic [7:0]  DI;
  logic        R_W_n;
  logic        VALID;
  logic [31:0] RD_DATA;
  logic [3:0]  SEL;
  logic [3:0]  WE;
  logic [7:0]  WD;
  logic [7:0]  DO;
  logic        RDY;
  logic        BUSERR;
  logic [15:0] ERR_ADDR;
  logic        ERR_CLR;

  always #5 CLK = ~CLK;

  io_decoder #(
    .NUM_REGIONS(4),
    .REGION_BITS(3),
    .REGION_BASE(12'b101_110_000_111),
    .REGION_WAIT(8'b01_11_10_00),
    .REGION_RO  (4'b0001),
    .OPEN_BUS   (8'hA5)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .A(A), .DI(DI), .R_W_n(R_W_n), .VALID(VALID),
    .RD_DATA(RD_DATA), .SEL(SEL), .WE(WE), .WD(WD), .DO(DO), .RDY(RDY),
    .BUSERR(BUSERR), .ERR_ADDR(ERR_ADDR), .ERR_CLR(ERR_CLR)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [3:0]  we;
    int          we_cycles;
    logic [7:0]  dov;
    logic [7:0]  wd;
    int          lat;
    logic        buserr;
    logic [15:0] err_addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_do = 8'hA5;
  logic        m_buserr = 1'b0;
  logic [15:0] m_err_addr = 16'h0000;

  function automatic int region_of(input logic [15:0] a);
    case (a[15:13])
      3'b111:  return 0;
      3'b000:  return 1;
      3'b110:  return 2;
      3'b101:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int wait_of(input int r);
    case (r)
      1:       return 2;
      2:       return 3;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] rd_byte(input int r);
    case (r)
      0:       return 8'h4C;
      1:       return 8'h91;
      2:       return 8'hC7;
      default: return 8'h3D;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic [15:0] addr, input logic rw,
                        input logic [7:0] di, input bit hold, input bit clr);
    exp_t       e;
    int         r;
    int         c;
    int         wec;
    int         extra;
    logic       old;
    logic [3:0] we_acc;
    logic [3:0] sel_first;
    r           = region_of(addr);
    e.sel       = (r >= 0) ? (4'b0001 << r) : 4'b0000;
    e.we        = (r > 0 && !rw) ? (4'b0001 << r) : 4'b0000;
    e.we_cycles = (e.we != 4'b0000) ? 1 : 0;
    e.wd        = di;
    if (rw) m_do = (r >= 0) ? rd_byte(r) : 8'hA5;
    e.dov       = m_do;
    e.lat       = wait_of(r) + 1;
`ifdef IO_DECODER_BUSERR_EN
    old = m_buserr;
    if (clr) m_buserr = 1'b0;
    if (r < 0) begin
      if (!old) m_err_addr = addr;
      m_buserr = 1'b1;
    end
`else
    old = 1'b0;
`endif
    e.buserr   = m_buserr;
    e.err_addr = m_err_addr;
    sb.push_back(e);

    @(negedge CLK);
    A = addr; R_W_n = rw; DI = di; VALID = 1'b1; ERR_CLR = clr;
    @(posedge CLK); #1;
    if (!hold) VALID = 1'b0;
    ERR_CLR   = 1'b0;
    sel_first = SEL;
    we_acc    = WE;
    wec       = (WE != 4'b0000) ? 1 : 0;
    c         = 0;
    while (RDY !== 1'b1 && c < 40) begin
      @(posedge CLK); #1;
      c++;
      we_acc = we_acc | WE;
      if (WE != 4'b0000) wec++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, c, e.lat);
    chk({tag, " sel_latch"}, sel_first, e.sel);
    chk({tag, " sel_done"}, SEL, e.sel);
    chk({tag, " do"}, DO, e.dov);
    chk({tag, " wd"}, WD, e.wd);
    chk({tag, " we"}, we_acc, e.we);
    chk({tag, " we_cycles"}, wec, e.we_cycles);
    chk({tag, " buserr"}, BUSERR, e.buserr);
    chk({tag, " err_addr"}, ERR_ADDR, e.err_addr);
    @(posedge CLK); #1;
    VALID = 1'b0;
    chk({tag, " rdy_one_cycle"}, RDY, 1'b0);
    chk({tag, " sel_idle"}, SEL, 4'b0000);
    extra = 0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (RDY === 1'b1) extra++;
    end
    chk({tag, " no_extra_rdy"}, extra, 0);
  endtask

  initial begin
    int rdy_seen;
    int we_seen;
    RESET_n = 1'b0;
    A = 16'h0000; DI = 8'h00; R_W_n = 1'b1; VALID = 1'b0; ERR_CLR = 1'b0;
    RD_DATA = {8'h3D, 8'hC7, 8'h91, 8'h4C};
    repeat (2) @(posedge CLK);
    #1;
    chk("reset sel", SEL, 4'b0000);
    chk("reset we", WE, 4'b0000);
    chk("reset rdy", RDY, 1'b0);
    chk("reset do", DO, 8'hA5);
    chk("reset wd", WD, 8'h00);
    chk("reset buserr", BUSERR, 1'b0);
    chk("reset err_addr", ERR_ADDR, 16'h0000);
    @(negedge CLK) RESET_n = 1'b1;

    access("rd_r0", 16'hE123, 1'b1, 8'h00, 1'b0, 1'b0);
    access("wr_r1", 16'h0010, 1'b0, 8'h5A, 1'b0, 1'b0);
    access("wr_r0_ro", 16'hE000, 1'b0, 8'h33, 1'b0, 1'b0);
    access("rd_r2", 16'hC004, 1'b1, 8'h11, 1'b0, 1'b0);
    access("rd_r3", 16'hA100, 1'b1, 8'h22, 1'b0, 1'b0);
    access("wr_r3", 16'hBFFF, 1'b0, 8'hE7, 1'b0, 1'b0);

    access("rd_unmapped", 16'h4000, 1'b1, 8'h00, 1'b0, 1'b0);
    access("wr_unmapped", 16'h6000, 1'b0, 8'h44, 1'b0, 1'b0);
    access("rd_unmapped_clr", 16'h4100, 1'b1, 8'h00, 1'b0, 1'b1);
    @(negedge CLK) ERR_CLR = 1'b1;
    @(posedge CLK); #1;
    ERR_CLR = 1'b0;
    m_buserr = 1'b0;
    chk("clr_only buserr", BUSERR, 1'b0);
    chk("clr_only err_addr", ERR_ADDR, m_err_addr);

    access("rd_r2_hold", 16'hC010, 1'b1, 8'h00, 1'b1, 1'b0);

    @(negedge CLK);
    A = 16'hC000; R_W_n = 1'b0; DI = 8'h77; VALID = 1'b1;
    @(posedge CLK); #1;
    VALID = 1'b0;
    chk("abort we_first", WE, 4'b0100);
    @(posedge CLK); #1;
    @(negedge CLK) RESET_n = 1'b0;
    #1;
    chk("abort sel", SEL, 4'b0000);
    chk("abort we", WE, 4'b0000);
    chk("abort rdy", RDY, 1'b0);
    chk("abort do", DO, 8'hA5);
    chk("abort wd", WD, 8'h00);
    chk("abort buserr", BUSERR, 1'b0);
    chk("abort err_addr", ERR_ADDR, 16'h0000);
    m_do = 8'hA5; m_buserr = 1'b0; m_err_addr = 16'h0000;
    rdy_seen = 0;
    we_seen  = 0;
    repeat (2) begin
      @(posedge CLK); #1;
      if (RDY === 1'b1) rdy_seen++;
      if (WE !== 4'b0000) we_seen++;
    end
    @(negedge CLK) RESET_n = 1'b1;
    repeat (5) begin
      @(posedge CLK); #1;
      if (RDY === 1'b1) rdy_seen++;
      if (WE !== 4'b0000) we_seen++;
    end
    chk("abort no_rdy", rdy_seen, 0);
    chk("abort no_we", we_seen, 0);

    access("rd_after_reset", 16'hE001, 1'b1, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_decoder.md
IO_DECODER -- requirements
Module: io_decoder

Interface
REQ-001 Parameters SHALL be: NUM_REGIONS (default 4, 1..8), number of decoded regions; REGION_BITS (default 3), top address bits decoded; REGION_BASE (default {3'b111,3'b000,3'b110,3'b101}, packed NUM_REGIONS*REGION_BITS, region 0 in LSBs), match value per region; REGION_WAIT (default 0, packed NUM_REGIONS*2), wait states 0..3 per region; REGION_RO (default 4'b0001), bitmask of regions whose writes are suppressed; OPEN_BUS (default 8'hA5), data returned for unmapped reads.
REQ-002 Ports SHALL be: CLK in 1, FPGA clock; RESET_n in 1, asynchronous active-low reset; A in 16, address; DI in 8, write data; R_W_n in 1, 1 read / 0 write; VALID in 1, access request strobe; RD_DATA in NUM_REGIONS*8, region read data (region i at bits 8i+7:8i); SEL out NUM_REGIONS, one-hot region select; WE out NUM_REGIONS, write strobes; WD out 8, latched write data; DO out 8, read data; RDY out 1, access-complete pulse; BUSERR out 1, sticky unmapped-access flag; ERR_ADDR out 16, address of first unmapped access; ERR_CLR in 1, clears BUSERR.

Function
REQ-003 Region i SHALL match when A[15:16-REGION_BITS] equals its REGION_BASE field; on multiple matches the lowest index SHALL win.
REQ-004 FSM SHALL have states IDLE, WAIT, DONE; IDLE is the reset state.
REQ-005 In IDLE, VALID sampled high SHALL latch A, R_W_n, DI (to WD) and matched index, load wait counter with REGION_WAIT of that region (0 if unmapped), and enter WAIT.
REQ-006 In WAIT, counter nonzero SHALL decrement and stay; counter zero SHALL enter DONE at the next edge, capturing DO on reads.
REQ-007 DO on a mapped read SHALL be RD_DATA of the latched region sampled on the WAIT->DONE edge; on an unmapped read DO SHALL be OPEN_BUS; writes SHALL leave DO unchanged.
REQ-008 RDY SHALL be high exactly in DONE (one cycle); DONE SHALL return to IDLE unconditionally.
REQ-009 Latency: VALID sampled at edge k, wait W -> RDY high in the cycle after edge k+W+1.
REQ-010 SEL[i] SHALL be high from the edge latching the access through the end of DONE; all-zero for unmapped accesses and in IDLE.
REQ-011 WE[i] SHALL pulse for the first WAIT cycle only, on writes to a mapped region whose REGION_RO bit is 0; writes to read-only regions SHALL complete with RDY but no WE.
REQ-012 VALID asserted outside IDLE SHALL be ignored (no queueing).

Reset
REQ-013 RESET_n low SHALL asynchronously force: state IDLE, SEL=0, WE=0, RDY=0, DO=OPEN_BUS, WD=0, BUSERR=0, ERR_ADDR=0.
REQ-014 Reset mid-access SHALL abort it with no RDY and no further WE.

Configuration
REQ-015 With IO_DECODER_BUSERR_EN defined, an unmapped access (read or write) entering WAIT SHALL set BUSERR and, if BUSERR was 0, load ERR_ADDR with A; ERR_CLR high SHALL clear BUSERR at the next edge; simultaneous set and clear SHALL leave BUSERR set.
REQ-016 Without IO_DECODER_BUSERR_EN, BUSERR and ERR_ADDR SHALL be constant 0 and ERR_CLR ignored; all other behaviour identical.

Verification
REQ-017 Read A=16'hE123 (region 0, W=0), RD_DATA[7:0]=8'h4C -> SEL=0001, RDY one cycle after edge k+1, DO=8'h4C, WE=0.
REQ-018 Write A=16'h0010, DI=8'h5A to region 1 with REGION_WAIT=2 -> WE[1] one cycle, WD=8'h5A, RDY after edge k+3, DO unchanged.
REQ-019 Write to region 0 (read-only) -> RDY pulses, WE=0000.
REQ-020 Read A=16'h4000 (unmapped), macro defined -> DO=8'hA5, SEL=0, BUSERR=1, ERR_ADDR=16'h4000; second unmapped access at 16'h6000 keeps ERR_ADDR=16'h4000; ERR_CLR with a third unmapped access on the same edge -> BUSERR stays 1.
REQ-021 VALID held high during a W=3 access -> exactly one RDY per access; RESET_n low during WAIT -> RDY never asserts, all outputs at reset values.
